// File: rtl/xor_serial_sched.sv
// Round-robin scheduler feeding one shared bit-serial XOR gate (LSB first, one bit per cycle).
// Optional XOR_SCHED_PARITY_EN macro adds a serial parity accumulator on res_parity.
module xor_serial_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [IDW-1:0]         res_id,
    output logic                   res_parity
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   next_ptr;
    logic [IDW-1:0]   winner;
    logic             any_req;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             xor_bit;

    logic             load;
    logic             shift_en;
    logic             accept;

    // The only XOR in the datapath: one operand bit pair per cycle.
    assign xor_bit  = a_sh[0] ^ b_sh[0];
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign next_ptr = (res_id == IDW'(N_REQ - 1)) ? '0 : res_id + IDW'(1);

    // Winner search: first set req bit at or after rr_ptr, wrapping around.
    // The loop runs from the farthest offset down so the nearest one wins last.
    always_comb begin
        int idx;
        // NOTE: every comb output gets a default before any branch, so no latch is inferred.
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                winner  = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so all registers update together.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req)   state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        accept   = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                load = any_req;
            end
            SHIFT:   shift_en = 1'b1;
            DONE:    accept   = res_ready;
            default: busy     = 1'b0;
        endcase
    end

    // Grant pulse and requester bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            res_id <= '0;
            rr_ptr <= '0;
        end else begin
            gnt <= '0;
            if (load) begin
                gnt    <= N_REQ'(1) << winner;
                res_id <= winner;
            end
            if (accept) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Operand shift registers and bit counter; operands are frozen at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= a_in[int'(winner) * WIDTH +: WIDTH];
            b_sh <= b_in[int'(winner) * WIDTH +: WIDTH];
            cnt  <= '0;
        end else if (shift_en) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

    // Result assembly: each new bit enters at the MSB so the first bit ends at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            if (shift_en) begin
                res_data <= {xor_bit, res_data[WIDTH-1:1]};
                if (last_bit) begin
                    res_valid <= 1'b1;
                end
            end
            if (accept) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef XOR_SCHED_PARITY_EN
    logic par_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc <= 1'b0;
        end else if (load) begin
            par_acc <= 1'b0;
        end else if (shift_en) begin
            par_acc <= par_acc ^ xor_bit;
        end
    end

    assign res_parity = par_acc;
`else
    assign res_parity = 1'b0;
`endif

endmodule
